// File: rtl/cursor_overlay.sv
// cursor_overlay: one-cycle video stream stage that inverts pixels inside a
// CURSOR_W x CURSOR_H box. Cursor enable/position are latched at in_vsync so
// port changes take effect on the next frame only.
// Optional build macro CURSOR_BLINK_EN adds a per-frame blink with a period of
// BLINK_FRAMES frames per phase.
module cursor_overlay #(
   parameter int unsigned CURSOR_W     = 8,
   parameter int unsigned CURSOR_H     = 16,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic        vo_clk,
   input  logic        vo_reset,
   input  logic        cursor_en,
   input  logic [11:0] cursor_x,
   input  logic [11:0] cursor_y,
   input  logic        in_vsync,
   input  logic        in_req,
   input  logic        in_eol,
   input  logic        in_eof,
   input  logic [23:0] in_pixel,
   output logic        out_vsync,
   output logic        out_req,
   output logic        out_eol,
   output logic        out_eof,
   output logic [23:0] out_pixel
);

   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic        en_q;
   logic [11:0] cx_q;
   logic [11:0] cy_q;

   // Values seen by the hit test this cycle; vsync wins over a coincident
   // pixel, which is then treated as (0,0) of the freshly latched cursor.
   logic        en_eff;
   logic [11:0] cx_eff;
   logic [11:0] cy_eff;
   logic [11:0] x_eff;
   logic [11:0] y_eff;
   logic        vis_eff;
   logic [12:0] x_end;
   logic [12:0] y_end;
   logic        hit;
   logic [23:0] pixel_d;

`ifdef CURSOR_BLINK_EN
   logic [7:0] frame_q;
   logic       phase_vis_q;
   // Blink phase latched per frame alongside the cursor shadow registers.
   logic       vis_q;

   // Frame counter and blink phase advance on every vsync.
   always_ff @(posedge vo_clk or posedge vo_reset) begin
      if (vo_reset) begin
         frame_q     <= 8'd0;
         phase_vis_q <= 1'b1;
         vis_q       <= 1'b1;
      end else if (in_vsync) begin
         vis_q <= phase_vis_q;
         if (frame_q == 8'(BLINK_FRAMES - 1)) begin
            frame_q     <= 8'd0;
            phase_vis_q <= ~phase_vis_q;
         end else begin
            frame_q <= frame_q + 8'd1;
         end
      end
   end

   assign vis_eff = in_vsync ? phase_vis_q : vis_q;
`else
   // Steady cursor: the blink parameter has no effect in this build.
   logic unused_blink;
   assign unused_blink = ^BLINK_FRAMES;
   assign vis_eff      = 1'b1;
`endif

   // Column/line counter next-state with saturation at 4095.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (in_vsync) begin
         x_d = 12'd0;
         y_d = 12'd0;
      end else if (in_req) begin
         if (in_eof) begin
            x_d = 12'd0;
            y_d = 12'd0;
         end else if (in_eol) begin
            x_d = 12'd0;
            y_d = (y_q == 12'hFFF) ? y_q : y_q + 12'd1;
         end else begin
            x_d = (x_q == 12'hFFF) ? x_q : x_q + 12'd1;
         end
      end
   end

   // Hit test on the pre-update position; 13-bit bounds avoid wrap near 4095.
   always_comb begin
      en_eff  = in_vsync ? cursor_en : en_q;
      cx_eff  = in_vsync ? cursor_x  : cx_q;
      cy_eff  = in_vsync ? cursor_y  : cy_q;
      x_eff   = in_vsync ? 12'd0     : x_q;
      y_eff   = in_vsync ? 12'd0     : y_q;
      x_end   = {1'b0, cx_eff} + 13'(CURSOR_W);
      y_end   = {1'b0, cy_eff} + 13'(CURSOR_H);
      hit     = in_req & en_eff & vis_eff
              & (x_eff >= cx_eff) & ({1'b0, x_eff} < x_end)
              & (y_eff >= cy_eff) & ({1'b0, y_eff} < y_end);
      pixel_d = hit ? ~in_pixel : in_pixel;
   end

   // Counters, cursor shadow registers and the registered output stage.
   always_ff @(posedge vo_clk or posedge vo_reset) begin
      if (vo_reset) begin
         x_q       <= 12'd0;
         y_q       <= 12'd0;
         en_q      <= 1'b0;
         cx_q      <= 12'd0;
         cy_q      <= 12'd0;
         out_vsync <= 1'b0;
         out_req   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
         out_pixel <= 24'd0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         if (in_vsync) begin
            en_q <= cursor_en;
            cx_q <= cursor_x;
            cy_q <= cursor_y;
         end
         out_vsync <= in_vsync;
         out_req   <= in_req;
         out_eol   <= in_eol;
         out_eof   <= in_eof;
         out_pixel <= pixel_d;
      end
   end

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay (CURSOR_W=8, CURSOR_H=16, BLINK_FRAMES=2).
module tb_cursor_overlay;

   logic        vo_clk = 1'b0;
   logic        vo_reset;
   logic        cursor_en;
   logic [11:0] cursor_x;
   logic [11:0] cursor_y;
   logic        in_vsync;
   logic        in_req;
   logic        in_eol;
   logic        in_eof;
   logic [23:0] in_pixel;
   logic        out_vsync;
   logic        out_req;
   logic        out_eol;
   logic        out_eof;
   logic [23:0] out_pixel;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 vo_clk = ~vo_clk;

   cursor_overlay #(
      .CURSOR_W    (8),
      .CURSOR_H    (16),
      .BLINK_FRAMES(2)
   ) dut (
      .vo_clk   (vo_clk),
      .vo_reset (vo_reset),
      .cursor_en(cursor_en),
      .cursor_x (cursor_x),
      .cursor_y (cursor_y),
      .in_vsync (in_vsync),
      .in_req   (in_req),
      .in_eol   (in_eol),
      .in_eof   (in_eof),
      .in_pixel (in_pixel),
      .out_vsync(out_vsync),
      .out_req  (out_req),
      .out_eol  (out_eol),
      .out_eof  (out_eof),
      .out_pixel(out_pixel)
   );

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic pix(input logic v, input logic r, input logic l, input logic f,
                      input logic [23:0] p);
      in_vsync = v;
      in_req   = r;
      in_eol   = l;
      in_eof   = f;
      in_pixel = p;
      @(posedge vo_clk);
      #1;
   endtask

   // Pulse reset for one cycle with all inputs idle (clears blink state too).
   task automatic apply_reset();
      vo_reset = 1'b1;
      pix(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
      vo_reset = 1'b0;
   endtask

   task automatic test_reset();
      vo_reset  = 1'b1;
      cursor_en = 1'b0;
      cursor_x  = 12'd0;
      cursor_y  = 12'd0;
      pix(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
      tests_run++;
      if ({out_vsync, out_req, out_eol, out_eof, out_pixel} !== 28'd0) begin
         tests_failed++;
         $display("FAIL por: got outputs=%h, want 0",
                  {out_vsync, out_req, out_eol, out_eof, out_pixel});
      end
      vo_reset = 1'b0;
      pix(1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
      // Reset asserted mid-cycle while the stream is active.
      vo_reset = 1'b1;
      pix(1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
      tests_run++;
      if ({out_vsync, out_req, out_eol, out_eof, out_pixel} !== 28'd0) begin
         tests_failed++;
         $display("FAIL mid_reset: got outputs=%h, want 0",
                  {out_vsync, out_req, out_eol, out_eof, out_pixel});
      end
      vo_reset = 1'b0;
      pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
      tests_run++;
      if (out_vsync !== 1'b1 || out_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL vsync_pass: got vsync=%b req=%b, want 1 0", out_vsync, out_req);
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 16; c++) begin
            pix(1'b0, 1'b1, c == 15, (c == 15) && (r == 3), 24'h123456);
            tests_run++;
            if (out_pixel !== 24'h123456 || out_req !== 1'b1 || out_vsync !== 1'b0 ||
                out_eol !== (c == 15) || out_eof !== ((c == 15) && (r == 3))) begin
               tests_failed++;
               $display("FAIL passthru r=%0d c=%0d: got pix=%h req=%b eol=%b eof=%b, want pix=123456 eol=%b eof=%b",
                        r, c, out_pixel, out_req, out_eol, out_eof, c == 15,
                        (c == 15) && (r == 3));
            end
         end
      end
   endtask

   task automatic test_cursor_box();
      logic [23:0] exp;
      apply_reset();
      cursor_en = 1'b1;
      cursor_x  = 12'd2;
      cursor_y  = 12'd1;
      pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 16; c++) begin
            pix(1'b0, 1'b1, c == 15, (c == 15) && (r == 3), 24'h00FF00);
            exp = (r >= 1 && c >= 2 && c <= 9) ? 24'hFF00FF : 24'h00FF00;
            tests_run++;
            if (out_pixel !== exp || out_eol !== (c == 15) ||
                out_eof !== ((c == 15) && (r == 3))) begin
               tests_failed++;
               $display("FAIL box r=%0d c=%0d: got pix=%h eol=%b eof=%b, want pix=%h",
                        r, c, out_pixel, out_eol, out_eof, exp);
            end
         end
      end
   endtask

   task automatic test_mid_frame_move();
      logic [23:0] exp;
      apply_reset();
      cursor_en = 1'b1;
      cursor_x  = 12'd2;
      cursor_y  = 12'd1;
      pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 16; c++) begin
            if (r == 1 && c == 0) cursor_x = 12'd5;
            pix(1'b0, 1'b1, c == 15, (c == 15) && (r == 3), 24'h00FF00);
            exp = (r >= 1 && c >= 2 && c <= 9) ? 24'hFF00FF : 24'h00FF00;
            tests_run++;
            if (out_pixel !== exp) begin
               tests_failed++;
               $display("FAIL move_old r=%0d c=%0d: got pix=%h, want pix=%h",
                        r, c, out_pixel, exp);
            end
         end
      end
      pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 16; c++) begin
            pix(1'b0, 1'b1, c == 15, (c == 15) && (r == 3), 24'h00FF00);
            exp = (r >= 1 && c >= 5 && c <= 12) ? 24'hFF00FF : 24'h00FF00;
            tests_run++;
            if (out_pixel !== exp) begin
               tests_failed++;
               $display("FAIL move_new r=%0d c=%0d: got pix=%h, want pix=%h",
                        r, c, out_pixel, exp);
            end
         end
      end
   endtask

   task automatic test_right_edge();
      logic [23:0] exp;
      apply_reset();
      cursor_en = 1'b1;
      cursor_x  = 12'd4092;
      cursor_y  = 12'd0;
      pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
      for (int c = 0; c < 4096; c++) begin
         pix(1'b0, 1'b1, c == 4095, 1'b0, 24'hA5A5A5);
         exp = (c >= 4092) ? 24'h5A5A5A : 24'hA5A5A5;
         tests_run++;
         if (out_pixel !== exp) begin
            tests_failed++;
            $display("FAIL edge_line0 c=%0d: got pix=%h, want pix=%h", c, out_pixel, exp);
         end
      end
      for (int c = 0; c < 4; c++) begin
         pix(1'b0, 1'b1, c == 3, c == 3, 24'hA5A5A5);
         tests_run++;
         if (out_pixel !== 24'hA5A5A5) begin
            tests_failed++;
            $display("FAIL edge_line1 c=%0d: got pix=%h, want pix=a5a5a5", c, out_pixel);
         end
      end
   endtask

   task automatic test_req_gaps();
      logic [23:0] exp;
      apply_reset();
      cursor_en = 1'b1;
      cursor_x  = 12'd2;
      cursor_y  = 12'd1;
      pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 16; c++) begin
            pix(1'b0, 1'b1, c == 15, (c == 15) && (r == 3), 24'h00FF00);
            exp = (r >= 1 && c >= 2 && c <= 9) ? 24'hFF00FF : 24'h00FF00;
            tests_run++;
            if (out_pixel !== exp || out_req !== 1'b1) begin
               tests_failed++;
               $display("FAIL gaps_pix r=%0d c=%0d: got pix=%h req=%b, want pix=%h req=1",
                        r, c, out_pixel, out_req, exp);
            end
            pix(1'b0, 1'b0, 1'b0, 1'b0, 24'h123400);
            tests_run++;
            if (out_pixel !== 24'h123400 || out_req !== 1'b0) begin
               tests_failed++;
               $display("FAIL gaps_idle r=%0d c=%0d: got pix=%h req=%b, want pix=123400 req=0",
                        r, c, out_pixel, out_req);
            end
         end
      end
   endtask

`ifdef CURSOR_BLINK_EN
   task automatic test_blink();
      logic [23:0] exp;
      logic        vis;
      apply_reset();
      cursor_en = 1'b1;
      cursor_x  = 12'd2;
      cursor_y  = 12'd1;
      for (int f = 0; f < 6; f++) begin
         vis = (f < 2) || (f >= 4);
         pix(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
               pix(1'b0, 1'b1, c == 15, (c == 15) && (r == 3), 24'h00FF00);
               exp = (vis && r >= 1 && c >= 2 && c <= 9) ? 24'hFF00FF : 24'h00FF00;
               tests_run++;
               if (out_pixel !== exp) begin
                  tests_failed++;
                  $display("FAIL blink f=%0d r=%0d c=%0d: got pix=%h, want pix=%h",
                           f, r, c, out_pixel, exp);
               end
            end
         end
      end
   endtask
`endif

   initial begin
      vo_reset  = 1'b1;
      cursor_en = 1'b0;
      cursor_x  = 12'd0;
      cursor_y  = 12'd0;
      in_vsync  = 1'b0;
      in_req    = 1'b0;
      in_eol    = 1'b0;
      in_eof    = 1'b0;
      in_pixel  = 24'd0;
      test_reset();
      test_cursor_box();
      test_mid_frame_move();
      test_right_edge();
      test_req_gaps();
`ifdef CURSOR_BLINK_EN
      test_blink();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Single-clock video-stream stage in the vo_clk pixel pipeline.
- Sits between the test-pattern generator and the character generator.
- Passes the req/eol/eof/vsync pixel stream through with one cycle of latency.
- Inverts pixels inside a rectangular cursor box whose position comes from input ports, latched once per frame.

Parameters:
- CURSOR_W, 8: cursor width in pixels (1..64).
- CURSOR_H, 16: cursor height in lines (1..64).
- BLINK_FRAMES, 30: frames per blink phase (used only with CURSOR_BLINK_EN; 1..255).

Ports:
- vo_clk  in  1  pixel clock; all logic on rising edge.
- vo_reset  in  1  asynchronous active-high reset.
- cursor_en  in  1  cursor enable; sampled at in_vsync.
- cursor_x  in  12  cursor left column; sampled at in_vsync.
- cursor_y  in  12  cursor top line; sampled at in_vsync.
- in_vsync  in  1  frame-start pulse; precedes the first pixel of a frame.
- in_req  in  1  pixel valid this cycle.
- in_eol  in  1  last pixel of line; qualified by in_req.
- in_eof  in  1  last pixel of frame; qualified by in_req, coincides with in_eol.
- in_pixel  in  24  RGB 8:8:8, R in [23:16].
- out_vsync  out  1  registered in_vsync.
- out_req  out  1  registered in_req.
- out_eol  out  1  registered in_eol.
- out_eof  out  1  registered in_eof.
- out_pixel  out  24  registered pixel, possibly inverted.

Behaviour:
- Reset (async, vo_reset=1): all outputs 0; column/line counters 0; shadow cursor_en/x/y 0 (cursor disabled); blink phase = visible, frame counter 0.
- Latency: exactly 1 cycle for every in_* to out_* path. No back-pressure; the block accepts every cycle.
- out_vsync, out_req, out_eol and out_eof copy their inputs unmodified.
- When in_req=0, out_pixel = in_pixel (don't-care, passed through).

Counters (12-bit column x, 12-bit line y):
- in_vsync=1: x and y cleared to 0. Shadow cursor_en/x/y loaded from the ports.
- in_req & in_eof: x and y cleared to 0.
- in_req & in_eol (not eof): x cleared, y incremented.
- in_req alone: x incremented.
- If in_vsync and in_req occur in the same cycle, vsync wins: counters cleared; the pixel is treated as x=0, y=0.
- Counters saturate at 4095; they never wrap.

Hit test (combinational on the current x,y before update):
- hit = en_s & (x >= cx_s) & (x < cx_s+CURSOR_W) & (y >= cy_s) & (y < cy_s+CURSOR_H).
- Sums are computed in 13 bits, so a cursor near 4095 never wraps to column/line 0.
- out_pixel = hit ? ~in_pixel : in_pixel (bitwise invert of all 24 bits).

Position updates:
- Port changes mid-frame have no effect until the next in_vsync.
- A cursor straddling the right or bottom edge is clipped naturally.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - 8-bit frame counter increments on each in_vsync.
  - When it reaches BLINK_FRAMES-1, it clears and the blink phase toggles.
  - hit is additionally ANDed with phase==visible.
  - The counter and phase reset only via vo_reset; cursor_en does not affect them.
- Undefined: no counter or phase logic; the cursor is steady whenever en_s=1.

Test Plan:
- Reset mid-stream -> on the next edge all out_* = 0. After release with cursor_en=0, a 16x4 frame of pixel 24'h123456 emerges unchanged, one cycle late, with matching eol/eof.
- cursor_en=1, cursor_x=2, cursor_y=1, CURSOR_W=8, CURSOR_H=16, 16x4 frame of 24'h00FF00 -> rows 1..3 cols 2..9 = 24'hFF00FF; all other pixels 24'h00FF00.
- Change cursor_x from 2 to 5 mid-frame -> current frame keeps cols 2..9; next frame after in_vsync inverts cols 5..12.
- cursor_x=4092, cursor_y=0, 4096-wide line -> only cols 4092..4095 inverted; col 0 of that line untouched.
- in_req gaps (req=0 every other cycle) -> column count advances only on req; inverted region is still cols 2..9.
- With CURSOR_BLINK_EN and BLINK_FRAMES=2, cursor on -> inversion present in frames 0-1, absent in frames 2-3, present in frames 4-5.
